// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and default sizing for the UART transmit byte buffer.
// Imported by the interface, the storage array and the top module.
package uart_tx_fifo_pkg;

    localparam int DEPTH_LOG2_DEF   = 4;
    localparam int BUSY_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BUSY  = 2'd1,
        WAIT_READY = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Core-side write port and UART-side handshake of the transmit byte buffer.
// The master drives strobes and the UART idle level; the slave is the buffer.
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);

    logic                  flush;
    logic                  push;
    logic [7:0]            pushData;
    logic                  coreReady;
    logic                  tx_ready;
    logic                  start_transmit;
    logic [7:0]            data_tx;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (
        output flush, push, pushData, tx_ready,
        input  coreReady, start_transmit, data_tx, count, overflow
    );

    modport slave (
        input  flush, push, pushData, tx_ready,
        output coreReady, start_transmit, data_tx, count, overflow
    );

endinterface

// File: rtl/uart_tx_fifo_ram.sv
// Byte storage for the transmit buffer: synchronous write, asynchronous read.
// Contents carry no reset; validity is tracked by the pointers in the top.
module byte_fifo_ram
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  sysClk,
    input  logic                  wrEn,
    input  logic [DEPTH_LOG2-1:0] wrAddr,
    input  logic [7:0]            wrData,
    input  logic [DEPTH_LOG2-1:0] rdAddr,
    output logic [7:0]            rdData
);

    logic [7:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge sysClk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer between the core output port and the UART: queues
// bytes from one-cycle pushes and issues one start pulse per byte.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic          sysClk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);

    localparam int DEPTH        = 1 << DEPTH_LOG2;
    localparam int TIMER_W      = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int TIMER_LAST_I = BUSY_TIMEOUT - 1;
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_LAST_I[TIMER_W-1:0];
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = DEPTH[DEPTH_LOG2:0];

    tx_state_e             state;
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   count;
    logic [TIMER_W-1:0]    busyTimer;
    logic                  startPulse;
    logic [7:0]            dataTx;
    logic                  overflowFlag;
    logic [7:0]            rdData;
    logic                  full;
    logic                  empty;
    logic                  doPop;
    logic                  doPush;
    logic                  dropPush;

    assign full  = (count == COUNT_FULL);
    assign empty = (count == '0);

    // A pop frees a slot on the same edge, so a push while full still fits.
    assign doPop    = (state == IDLE) && !empty && bus.tx_ready;
    assign doPush   = bus.push && !bus.flush && (!full || doPop);
    assign dropPush = bus.push && !bus.flush && full && !doPop;

    byte_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .sysClk (sysClk),
        .wrEn   (doPush),
        .wrAddr (wrPtr),
        .wrData (bus.pushData),
        .rdAddr (rdPtr),
        .rdData (rdData)
    );

    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (bus.flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (!doPush && doPop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            overflowFlag <= 1'b0;
        end else if (dropPush) begin
            overflowFlag <= 1'b1;
        end
    end

    // Flush leaves this FSM alone so a frame already handed to the UART finishes.
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busyTimer  <= '0;
            startPulse <= 1'b0;
            dataTx     <= 8'h00;
        end else begin
            startPulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (doPop) begin
                        dataTx     <= rdData;
                        startPulse <= 1'b1;
                        busyTimer  <= '0;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    busyTimer <= busyTimer + 1'b1;
                    if (!bus.tx_ready || (busyTimer == TIMER_LAST)) begin
                        state <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (bus.tx_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.coreReady      = !full;
    assign bus.start_transmit = startPulse;
    assign bus.data_tx        = dataTx;
    assign bus.count          = count;
    assign bus.overflow       = overflowFlag;

endmodule
